// File: rtl/rol_seq.sv
// Sequential left-rotator: shifts the captured operand one bit per cycle until
// the requested amount is used up, then raises done for a single cycle.
module rol_seq #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] num_rotate,
  output logic [DATA_W-1:0]  data_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [SHAMT_W-1:0] cnt;

  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], v[DATA_W-1]};
  endfunction

  // data_out is the working register itself, so the result holds while idle
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      data_out <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            data_out <= data_in;
            cnt      <= num_rotate;
            busy     <= 1'b1;
            if (num_rotate == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          data_out <= rotl1(data_out);
          cnt      <= cnt - 1'b1;
          // last rotation: done lines up with the final value
          if (cnt == SHAMT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rol_seq.sv
// Bench for rol_seq: table vectors, hand-written corner sequences and random
// operations checked against a plain-arithmetic rotate model.
module tb_rol_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  num_rotate;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

  rol_seq #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .clr(clr), .start(start), .data_in(data_in),
    .num_rotate(num_rotate), .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [4:0]  num;
    logic [31:0] exp_out;
    int          exp_lat;
  } vec_t;

  function automatic logic [31:0] rotl_ref(input logic [31:0] x, input int k);
    logic [63:0] wide;
    wide = {32'h0, x} << k;
    return wide[31:0] | wide[63:32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge; start is raised in the current cycle.
  task automatic do_op(input string name, input logic [31:0] din, input logic [4:0] k,
                       input logic [31:0] exp_out, input int exp_lat, input int repulse);
    int n, busy_cnt;
    start = 1'b1; data_in = din; num_rotate = k;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; data_in = $urandom; num_rotate = 5'($urandom);
    n = 1; busy_cnt = 0;
    while (n <= 64) begin
      if (busy) busy_cnt++;
      if (done) break;
      if (repulse > 0 && n == repulse) begin
        start = 1'b1; data_in = 32'hFFFF_FFFF; num_rotate = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " result"}, data_out, exp_out);
    check({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    @(negedge clk);
    check({name, " done one cycle"}, {31'h0, done}, 32'h0);
    check({name, " idle busy"}, {31'h0, busy}, 32'h0);
    check({name, " hold"}, data_out, exp_out);
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{32'h0000_0001, 5'd1,  32'h0000_0002, 2};
    vecs[1] = '{32'h8000_0000, 5'd1,  32'h0000_0001, 2};
    vecs[2] = '{32'h0000_000F, 5'd8,  32'h0000_0F00, 9};
    vecs[3] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
    vecs[4] = '{32'h1234_5678, 5'd31, 32'h091A_2B3C, 32};

    clr = 1'b0; start = 1'b0; data_in = '0; num_rotate = '0;

    // reset held with start asserted must keep outputs at reset values
    @(negedge clk);
    start = 1'b1; data_in = 32'hA5A5_A5A5; num_rotate = 5'd3;
    repeat (3) begin
      @(negedge clk);
      check("reset data_out", data_out, 32'h0);
      check("reset busy", {31'h0, busy}, 32'h0);
      check("reset done", {31'h0, done}, 32'h0);
    end
    start = 1'b0;
    clr = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      do_op($sformatf("vec%0d", i), vecs[i].din, vecs[i].num, vecs[i].exp_out, vecs[i].exp_lat, 0);

    // second request while busy must be dropped
    do_op("repulse", 32'h0000_0001, 5'd4, 32'h0000_0010, 5, 2);

    // abort mid-operation with a single clr edge
    start = 1'b1; data_in = 32'h0000_0001; num_rotate = 5'd20;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    check("abort data_out", data_out, 32'h0);
    check("abort busy", {31'h0, busy}, 32'h0);
    check("abort done", {31'h0, done}, 32'h0);
    begin
      int seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("abort no done", 32'(seen), 32'h0);
    end
    do_op("after abort", 32'h0000_0001, 5'd2, 32'h0000_0004, 3, 0);

    // randomized back-to-back operations against the model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] d;
      int k;
      d = $urandom;
      k = int'($urandom_range(0, 31));
      do_op($sformatf("rand%0d", i), d, 5'(k), rotl_ref(d, k), k + 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
